// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: stage register numbers and enables in,
// stall/flush/forward controls and the stall performance counter out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       RsD, RtD, RsE, RtE;
    logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, MemtoRegM;
    logic             BranchD, PCSrcD, MultStartE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;
    logic             ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MultDoneE;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MultStartE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE, MultDoneE, StallCnt
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MultStartE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAD, ForwardBD, ForwardAE, ForwardBE, MultDoneE, StallCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: forwarding selects, load-use and
// branch stalls, control flushes, MULT/DIV sequencing and a saturating stall counter.
//   state | meaning
//   IDLE  | no multi-cycle op in flight; a MultStartE here stalls and loads cnt
//   BUSY  | MULT/DIV still computing; cnt counts down to the terminal value 1
module hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 32
) (
    input logic          CLK,
    input logic          RST,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             done_q;
    logic [CNT_W-1:0] stall_cnt;

    logic       lwstall, brstall, mstall, stall_fd;
    logic       e_hit, m_hit;
    logic [1:0] fwd_ae, fwd_be;

    always_comb begin
        fwd_ae = 2'b00;
        if (hz.RegWriteM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RsE)
            fwd_ae = 2'b10;
        else if (hz.RegWriteW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RsE)
            fwd_ae = 2'b01;
    end

    always_comb begin
        fwd_be = 2'b00;
        if (hz.RegWriteM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RtE)
            fwd_be = 2'b10;
        else if (hz.RegWriteW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RtE)
            fwd_be = 2'b01;
    end

    assign e_hit = hz.WriteRegE != 5'd0 &&
                   (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD);
    assign m_hit = hz.WriteRegM != 5'd0 &&
                   (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD);

    assign lwstall  = hz.MemtoRegE && e_hit;
    assign brstall  = hz.BranchD && ((hz.RegWriteE && e_hit) || (hz.MemtoRegM && m_hit));
    assign mstall   = (state == IDLE && hz.MultStartE) || state == BUSY;
    assign stall_fd = mstall || lwstall || brstall;

    // Reset forces a clean pipeline: nothing held, every stage register cleared.
    assign hz.StallF    = ~RST & stall_fd;
    assign hz.StallD    = ~RST & stall_fd;
    assign hz.StallE    = ~RST & mstall;
    assign hz.FlushM    =  RST | mstall;
    assign hz.FlushE    =  RST | (~mstall & (lwstall | brstall));
    assign hz.FlushD    =  RST | (hz.PCSrcD & ~stall_fd);
    assign hz.ForwardAE = RST ? 2'b00 : fwd_ae;
    assign hz.ForwardBE = RST ? 2'b00 : fwd_be;
    assign hz.ForwardAD = ~RST & hz.RegWriteM & (hz.RsD != 5'd0) & (hz.RsD == hz.WriteRegM);
    assign hz.ForwardBD = ~RST & hz.RegWriteM & (hz.RtD != 5'd0) & (hz.RtD == hz.WriteRegM);
    assign hz.MultDoneE = ~RST & done_q;
    assign hz.StallCnt  = stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            done_q    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hz.MultStartE) begin
                        cnt <= 4'(MULT_LAT - 2);
                        if (MULT_LAT > 2) state  <= BUSY;
                        else              done_q <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (stall_fd && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: dut4 (MULT_LAT=4, 32-bit counter) and dut2 (MULT_LAT=2, 4-bit counter).
module tb_hazard_ctrl;
    logic CLK = 1'b0;
    logic rst_a, rst_b;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_if #(.CNT_W(32)) ia ();
    hazard_ctrl_if #(.CNT_W(4))  ib ();

    hazard_ctrl #(.MULT_LAT(4), .CNT_W(32)) dut4 (.CLK(CLK), .RST(rst_a), .hz(ia));
    hazard_ctrl #(.MULT_LAT(2), .CNT_W(4))  dut2 (.CLK(CLK), .RST(rst_b), .hz(ib));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_a();
        {ia.RsD, ia.RtD, ia.RsE, ia.RtE} = '0;
        {ia.WriteRegE, ia.WriteRegM, ia.WriteRegW} = '0;
        {ia.RegWriteE, ia.RegWriteM, ia.RegWriteW, ia.MemtoRegE, ia.MemtoRegM} = '0;
        {ia.BranchD, ia.PCSrcD, ia.MultStartE} = '0;
    endtask

    task automatic clr_b();
        {ib.RsD, ib.RtD, ib.RsE, ib.RtE} = '0;
        {ib.WriteRegE, ib.WriteRegM, ib.WriteRegW} = '0;
        {ib.RegWriteE, ib.RegWriteM, ib.RegWriteW, ib.MemtoRegE, ib.MemtoRegM} = '0;
        {ib.BranchD, ib.PCSrcD, ib.MultStartE} = '0;
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        clr_a();
        clr_b();
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.RegWriteM = 1'b1; ia.WriteRegM = 5'd8; ia.RsE = 5'd8;
        ia.MemtoRegE = 1'b1; ia.WriteRegE = 5'd9; ia.RtD = 5'd9; ia.MultStartE = 1'b1;
        @(negedge CLK);
        chk("rst_stallf", ia.StallF, 0);
        chk("rst_stalle", ia.StallE, 0);
        chk("rst_flushes", {ia.FlushD, ia.FlushE, ia.FlushM}, 3'b111);
        chk("rst_fwdae", ia.ForwardAE, 0);
        chk("rst_done", ia.MultDoneE, 0);
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        clr_a();
        @(negedge CLK);
        chk("rst_cnt", ia.StallCnt, 0);
        chk("idle_flushes", {ia.FlushD, ia.FlushE, ia.FlushM}, 3'b000);

        // Forwarding priority and the register-0 exclusion
        step();
        ia.RegWriteM = 1'b1; ia.WriteRegM = 5'd8; ia.RsE = 5'd8; ia.RtE = 5'd8;
        ia.RegWriteW = 1'b1; ia.WriteRegW = 5'd8; ia.RsD = 5'd8;
        @(negedge CLK);
        chk("fwd_ae_m", ia.ForwardAE, 2'b10);
        chk("fwd_be_m", ia.ForwardBE, 2'b10);
        chk("fwd_ad", ia.ForwardAD, 1);
        chk("fwd_bd_none", ia.ForwardBD, 0);
        chk("fwd_no_stall", ia.StallF, 0);
        #1 ia.WriteRegM = 5'd0;
        #1;
        chk("fwd_ae_w", ia.ForwardAE, 2'b01);
        chk("fwd_ad_r0", ia.ForwardAD, 0);
        #1 ia.RegWriteW = 1'b0;
        #1;
        chk("fwd_ae_none", ia.ForwardAE, 2'b00);

        // Load-use with a coincident taken branch: the stall must win over FlushD
        step();
        clr_a();
        ia.MemtoRegE = 1'b1; ia.WriteRegE = 5'd9; ia.RtD = 5'd9; ia.PCSrcD = 1'b1;
        @(negedge CLK);
        chk("lw_stall_fd", {ia.StallF, ia.StallD}, 2'b11);
        chk("lw_flushe", ia.FlushE, 1);
        chk("lw_flushd", ia.FlushD, 0);
        chk("lw_stalle", ia.StallE, 0);
        chk("lw_flushm", ia.FlushM, 0);
        step();
        ia.WriteRegE = 5'd0; ia.RtD = 5'd0; ia.PCSrcD = 1'b0;
        @(negedge CLK);
        chk("lw_cnt", ia.StallCnt, 1);
        chk("lw_r0_nostall", ia.StallF, 0);

        // Branch operand hazards from E (ALU result) and M (load)
        step();
        clr_a();
        ia.BranchD = 1'b1; ia.RsD = 5'd5; ia.RegWriteE = 1'b1; ia.WriteRegE = 5'd5;
        @(negedge CLK);
        chk("br_stall", ia.StallF, 1);
        chk("br_flushe", ia.FlushE, 1);
        step();
        ia.WriteRegE = 5'd0; ia.PCSrcD = 1'b1;
        @(negedge CLK);
        chk("br_taken_flushd", ia.FlushD, 1);
        chk("br_taken_nostall", ia.StallF, 0);
        chk("br_cnt", ia.StallCnt, 2);
        step();
        clr_a();
        ia.BranchD = 1'b1; ia.RtD = 5'd7; ia.MemtoRegM = 1'b1; ia.WriteRegM = 5'd7;
        @(negedge CLK);
        chk("br_load_m", ia.StallD, 1);
        step();
        clr_a();
        ia.BranchD = 1'b1; ia.RsD = 5'd5; ia.WriteRegE = 5'd5;
        @(negedge CLK);
        chk("br_no_regwrite", ia.StallD, 0);
        chk("br_cnt2", ia.StallCnt, 3);

        // MULT/DIV with MULT_LAT=4: three stall cycles, then a done pulse
        step();
        clr_a();
        ia.MultStartE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("m4_stall%0d", i), {ia.StallF, ia.StallD, ia.StallE, ia.FlushM}, 4'hF);
            chk($sformatf("m4_flush%0d", i), {ia.FlushE, ia.MultDoneE}, 2'b00);
            if (i < 2) step();
        end
        step();
        ia.MultStartE = 1'b0;
        @(negedge CLK);
        chk("m4_done", ia.MultDoneE, 1);
        chk("m4_nostall", {ia.StallF, ia.StallE, ia.FlushM}, 3'b000);
        chk("m4_cnt", ia.StallCnt, 6);
        step();
        @(negedge CLK);
        chk("m4_done_pulse", ia.MultDoneE, 0);

        // Reset in the middle of a MULT op aborts it
        step();
        ia.MultStartE = 1'b1;
        @(negedge CLK);
        chk("rm_stall", ia.StallE, 1);
        step();
        rst_a = 1'b1;
        @(negedge CLK);
        chk("rm_rst_stall", {ia.StallF, ia.StallE}, 2'b00);
        chk("rm_rst_flush", {ia.FlushD, ia.FlushE, ia.FlushM}, 3'b111);
        step();
        rst_a = 1'b0;
        ia.MultStartE = 1'b0;
        @(negedge CLK);
        chk("rm_idle", {ia.StallF, ia.StallD, ia.StallE, ia.FlushM}, 4'h0);
        chk("rm_nodone", ia.MultDoneE, 0);
        chk("rm_cnt", ia.StallCnt, 0);
        step();
        @(negedge CLK);
        chk("rm_nodone2", ia.MultDoneE, 0);
        chk("rm_stays_idle", ia.StallE, 0);

        // MULT_LAT=2 with a coincident load-use: single stall, mstall blocks FlushE
        step();
        clr_b();
        ib.MultStartE = 1'b1; ib.MemtoRegE = 1'b1; ib.WriteRegE = 5'd9; ib.RsD = 5'd9;
        @(negedge CLK);
        chk("m2_stalld", ib.StallD, 1);
        chk("m2_stalle", ib.StallE, 1);
        chk("m2_flushe", ib.FlushE, 0);
        chk("m2_flushm", ib.FlushM, 1);
        step();
        clr_b();
        @(negedge CLK);
        chk("m2_done", ib.MultDoneE, 1);
        chk("m2_nostall", {ib.StallF, ib.StallE}, 2'b00);
        chk("m2_cnt", ib.StallCnt, 1);

        // Saturation of the 4-bit stall counter
        step();
        ib.MemtoRegE = 1'b1; ib.WriteRegE = 5'd3; ib.RtD = 5'd3;
        for (int i = 0; i < 13; i++) step();
        @(negedge CLK);
        chk("sat_near", ib.StallCnt, 14);
        step();
        @(negedge CLK);
        chk("sat_max", ib.StallCnt, 15);
        for (int i = 0; i < 4; i++) step();
        @(negedge CLK);
        chk("sat_hold", ib.StallCnt, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
